// File: rtl/config_loader_pkg.sv
// Shared FSM encoding and default sizing for the configuration scan-chain loader.
package cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    localparam int WORD_W_DEF    = 32;
    localparam int CHAIN_LEN_DEF = 64;
    localparam int RST_CYC_DEF   = 4;

    // Width of a counter that must reach max_val without wrapping.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// Host-to-loader config word handshake; a word moves when cfg_valid && cfg_ready.
interface config_loader_if #(
    parameter int WORD_W = 32
) ();

    logic              cfg_valid;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );

endinterface

// File: rtl/config_loader.sv
// Clears a PE config scan chain, then shifts CHAIN_LEN host bits in (2 clk per bit, bit 0 first).
// Stalls indefinitely in FETCH until the host offers a word; flags any 1 pushed out of the chain tail.
module config_loader
    import cfg_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int RST_CYC   = RST_CYC_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    config_loader_if.slave cfg,
    output logic           config_clk,
    output logic           config_reset,
    output logic           config_in,
    input  logic           config_out,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int BC_W = cnt_w(CHAIN_LEN);
    localparam int WB_W = cnt_w(WORD_W);
    localparam int RC_W = cnt_w(RST_CYC);

    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0] WBIT_LAST = WB_W'(WORD_W - 1);
    localparam logic [RC_W-1:0] RST_LAST  = RC_W'(RST_CYC - 1);

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] shreg;
    logic [BC_W-1:0]   bitcnt;
    logic [WB_W-1:0]   wordbit;
    logic [RC_W-1:0]   rstcnt;

    // Chain controls are flopped from next_state so they cannot glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            config_clk   <= 1'b0;
            config_reset <= 1'b0;
        end else begin
            state        <= next_state;
            config_clk   <= (next_state == SHIFT_HI);
            config_reset <= (next_state == CLEAR);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = CLEAR;
            CLEAR:    if (rstcnt == RST_LAST) next_state = FETCH;
            FETCH:    if (cfg.cfg_valid) next_state = SHIFT_LO;
            SHIFT_LO: next_state = SHIFT_HI;
            SHIFT_HI: begin
                if (bitcnt == BIT_LAST)
                    next_state = DONE;
                else if (wordbit == WBIT_LAST)
                    next_state = FETCH;
                else
                    next_state = SHIFT_LO;
            end
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        cfg.cfg_ready = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        config_in     = 1'b0;
        case (state)
            IDLE:               busy          = 1'b0;
            FETCH:              cfg.cfg_ready = 1'b1;
            SHIFT_LO, SHIFT_HI: config_in     = shreg[0];
            DONE:               done          = 1'b1;
            default:            ;
        endcase
    end

    // The tail is sampled on the edge that raises config_clk, i.e. the bit being displaced.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg   <= '0;
            bitcnt  <= '0;
            wordbit <= '0;
            rstcnt  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    err    <= 1'b0;
                    bitcnt <= '0;
                    rstcnt <= '0;
                end
                CLEAR:    rstcnt <= rstcnt + 1'b1;
                FETCH: if (cfg.cfg_valid) begin
                    shreg   <= cfg.cfg_data;
                    wordbit <= '0;
                end
                SHIFT_LO: if (config_out) err <= 1'b1;
                SHIFT_HI: begin
                    shreg   <= shreg >> 1;
                    bitcnt  <= bitcnt + 1'b1;
                    wordbit <= wordbit + 1'b1;
                end
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench: a 64-bit and a 40-bit chain model, each behind its own loader instance.
module tb_config_loader;
    import cfg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        host_vld = 1'b0;
    logic [31:0] host_dat = '0;
    logic        preload = 1'b0;
    logic        ign = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    config_loader_if #(.WORD_W(32)) if64 ();
    config_loader_if #(.WORD_W(32)) if40 ();

    assign if64.cfg_valid = host_vld & ~sel;
    assign if64.cfg_data  = host_dat;
    assign if40.cfg_valid = host_vld & sel;
    assign if40.cfg_data  = host_dat;

    wire s64 = start & ~sel;
    wire s40 = start & sel;

    logic c64_clk, c64_rst, c64_in, b64, d64, e64;
    logic c40_clk, c40_rst, c40_in, b40, d40, e40;
    logic [63:0] m64 = '0;
    logic [39:0] m40 = '0;
    wire c64_out = m64[0];
    wire c40_out = m40[0];

    config_loader #(.WORD_W(32), .CHAIN_LEN(64), .RST_CYC(4)) dut64 (
        .clk(clk), .reset(reset), .start(s64), .cfg(if64.slave),
        .config_clk(c64_clk), .config_reset(c64_rst), .config_in(c64_in),
        .config_out(c64_out), .busy(b64), .done(d64), .err(e64)
    );

    config_loader #(.WORD_W(32), .CHAIN_LEN(40), .RST_CYC(4)) dut40 (
        .clk(clk), .reset(reset), .start(s40), .cfg(if40.slave),
        .config_clk(c40_clk), .config_reset(c40_rst), .config_in(c40_in),
        .config_out(c40_out), .busy(b40), .done(d40), .err(e40)
    );

    always #5 clk = ~clk;

    // Chain models: config_clk is high for exactly one clk cycle per bit, so one shift per high phase.
    always @(negedge clk) begin
        if (preload)              m64 = 64'h1;
        else if (c64_rst && !ign) m64 = '0;
        else if (c64_clk)         m64 = {c64_in, m64[63:1]};
    end

    always @(negedge clk) begin
        if (c40_rst)      m40 = '0;
        else if (c40_clk) m40 = {c40_in, m40[39:1]};
    end

    wire o_clk  = sel ? c40_clk : c64_clk;
    wire o_rst  = sel ? c40_rst : c64_rst;
    wire o_busy = sel ? b40 : b64;
    wire o_done = sel ? d40 : d64;
    wire o_err  = sel ? e40 : e64;
    wire o_rdy  = sel ? if40.cfg_ready : if64.cfg_ready;

    int   r_cyc, r_nw, r_rst, r_hi, r_stall_bad;
    logic r_err6, r_err7, r_done, r_done_err, r_busy_after;
    logic ab_clk_before, ab_clk, ab_busy, ab_rdy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One load, cycle by cycle; r_cyc counts cycles since the start edge (CLEAR = 1..4).
    task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                        input int stall, input int abort_at, input int spur_at);
        int idx;
        int stall_left;
        logic hs;
        idx = 0; stall_left = stall;
        r_nw = 0; r_rst = 0; r_hi = 0; r_stall_bad = 0;
        r_err6 = 1'bx; r_err7 = 1'bx;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r_cyc = 1;
        while (!o_done && r_cyc < 2000) begin
            if (o_rst) r_rst++;
            if (o_clk) r_hi++;
            if (r_cyc == 6) r_err6 = o_err;
            if (r_cyc == 7) r_err7 = o_err;
            if (r_cyc == abort_at) begin
                ab_clk_before = o_clk;
                reset = 1'b0; host_vld = 1'b0;
                @(posedge clk); #1;
                ab_clk = o_clk; ab_busy = o_busy; ab_rdy = o_rdy;
                reset = 1'b1;
                return;
            end
            start = (r_cyc == spur_at);
            host_vld = 1'b0;
            if (stall_left > 0 && (o_rdy || stall_left < stall)) begin
                stall_left--;
                if (!o_rdy || o_clk) r_stall_bad++;
            end else if (idx < 2) begin
                host_vld = 1'b1;
                host_dat = (idx == 0) ? w0 : w1;
            end
            hs = host_vld && o_rdy;
            @(posedge clk); #1;
            if (hs) begin idx++; r_nw++; end
            r_cyc++;
        end
        start = 1'b0; host_vld = 1'b0;
        r_done = o_done; r_done_err = o_err;
        @(posedge clk); #1;
        r_busy_after = o_busy;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out64", {c64_clk, c64_rst, c64_in, b64, d64, e64, if64.cfg_ready}, 0);
        check("reset_out40", {c40_clk, c40_rst, c40_in, b40, d40, e40, if40.cfg_ready}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Two full words into the 64-bit chain.
        load(32'hDEADBEEF, 32'h12345678, 0, -1, -1);
        check("t1_done", r_done, 1);
        check("t1_cycles", r_cyc, 135);
        check("t1_words", r_nw, 2);
        check("t1_rst_cyc", r_rst, 4);
        check("t1_clk_rises", r_hi, 64);
        check("t1_chain", m64, 64'h12345678_DEADBEEF);
        check("t1_err", r_done_err, 0);
        check("t1_busy_after", r_busy_after, 0);

        // Partial last word on the 40-bit chain.
        sel = 1'b1;
        load(32'hFFFFFFFF, 32'hFFFFFF0A, 0, -1, -1);
        check("t2_done", r_done, 1);
        check("t2_cycles", r_cyc, 87);
        check("t2_clk_rises", r_hi, 40);
        check("t2_words", r_nw, 2);
        check("t2_head8", {56'h0, m40[39:32]}, 64'h0A);
        check("t2_tail32", {32'h0, m40[31:0]}, 64'hFFFFFFFF);
        check("t2_err", r_done_err, 0);
        sel = 1'b0;

        // Host withholds the first word for 10 cycles.
        m64 = '0;
        load(32'hDEADBEEF, 32'h12345678, 10, -1, -1);
        check("t3_stall_ok", r_stall_bad, 0);
        check("t3_cycles", r_cyc, 145);
        check("t3_clk_rises", r_hi, 64);
        check("t3_chain", m64, 64'h12345678_DEADBEEF);

        // Chain ignores clear and holds a 1 at its tail.
        ign = 1'b1; preload = 1'b1;
        @(negedge clk); #1;
        preload = 1'b0;
        load(32'h0, 32'h0, 0, -1, -1);
        check("t4_err_before_hi", r_err6, 0);
        check("t4_err_first_hi", r_err7, 1);
        check("t4_err_at_done", r_done_err, 1);
        check("t4_err_sticky_idle", o_err, 1);
        ign = 1'b0;
        load(32'hDEADBEEF, 32'h12345678, 0, -1, -1);
        check("t4_err_cleared", r_err7, 0);
        check("t4_err_next_done", r_done_err, 0);
        check("t4_chain_next", m64, 64'h12345678_DEADBEEF);

        // Reset lands during SHIFT_HI of bit 17 (0-based).
        load(32'hCAFEF00D, 32'h0BADC0DE, 0, 7 + 2 * 17, -1);
        check("t5_in_shift_hi", ab_clk_before, 1);
        check("t5_clk_low", ab_clk, 0);
        check("t5_busy_low", ab_busy, 0);
        check("t5_rdy_low", ab_rdy, 0);
        load(32'hDEADBEEF, 32'h12345678, 0, -1, -1);
        check("t5_rst_cyc", r_rst, 4);
        check("t5_cycles", r_cyc, 135);
        check("t5_chain", m64, 64'h12345678_DEADBEEF);

        // Start coinciding with reset, then start repeated mid-load.
        reset = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_start_busy", o_busy, 0);
        check("t6_rst_start_clr", o_rst, 0);
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("t6_still_idle", o_busy, 0);
        load(32'hDEADBEEF, 32'h12345678, 0, -1, 2);
        check("t6_rst_cyc", r_rst, 4);
        check("t6_cycles", r_cyc, 135);
        check("t6_chain", m64, 64'h12345678_DEADBEEF);
        check("t6_idle_after", r_busy_after, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
